// File: rtl/pvt_sensor_seq_if.sv
// Sensor-side and result-write-side signals of the PVT measurement sequencer.
// master = sequencer, slave = sensor macros / register block.
interface pvt_sensor_seq_if #(
   parameter int NO_OF_SENSORS = 8,
   parameter int DATA_WIDTH    = 16,
   parameter int IDX_W         = (NO_OF_SENSORS > 1) ? $clog2(NO_OF_SENSORS) : 1
) ();
   logic [NO_OF_SENSORS-1:0]            sens_en;
   logic [NO_OF_SENSORS-1:0]            sens_valid;
   logic [NO_OF_SENSORS*DATA_WIDTH-1:0] sens_data;
   logic                                res_wr;
   logic [IDX_W-1:0]                    res_idx;
   logic [DATA_WIDTH-1:0]               res_data;
   logic                                res_timeout;

   modport master (
      output sens_en, res_wr, res_idx, res_data, res_timeout,
      input  sens_valid, sens_data
   );

   modport slave (
      input  sens_en, res_wr, res_idx, res_data, res_timeout,
      output sens_valid, sens_data
   );
endinterface

// File: rtl/pvt_sensor_seq.sv
// PVT sensor sequencer: walks masked sensors, pulses enable, writes result or timeout.
// Define PVT_SEQ_SYNC_VALID_EN to pass sens_valid through a 2-flop synchronizer.
module pvt_sensor_seq #(
   parameter int NO_OF_SENSORS = 8,
   parameter int DATA_WIDTH    = 16,
   parameter int IDX_W         = (NO_OF_SENSORS > 1) ? $clog2(NO_OF_SENSORS) : 1
) (
   input  logic                     s_apb_clk,
   input  logic                     s_apb_rstn,
   input  logic                     cfg_start,
   input  logic                     cfg_abort,
   input  logic                     cfg_continuous,
   input  logic [NO_OF_SENSORS-1:0] cfg_mask,
   input  logic [7:0]               cfg_settle,
   input  logic [15:0]              cfg_timeout,
   output logic                     busy,
   output logic                     done,
   output logic [7:0]               err_cnt,
   pvt_sensor_seq_if.master         sif
);
   // One extra index bit so "past the last sensor" is representable for the end-of-pass check
   localparam int IW = IDX_W + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_SELECT, ST_ENABLE, ST_WAIT, ST_WRITE} state_t;

   state_t                   state;
   logic [IW-1:0]            idx;
   logic [NO_OF_SENSORS-1:0] mask_q;
   logic [NO_OF_SENSORS-1:0] valid_use;
   logic [7:0]               settle_q;
   logic [7:0]               set_cnt;
   logic [15:0]              timeout_q;
   logic [15:0]              timer;
   logic                     cont_q;
   logic                     found;
   logic [IDX_W-1:0]         sel;
   logic [IDX_W-1:0]         cur;
   logic [DATA_WIDTH-1:0]    cur_data;

   assign busy = (state != ST_IDLE);
   assign cur  = idx[IDX_W-1:0];

`ifdef PVT_SEQ_SYNC_VALID_EN
   logic [NO_OF_SENSORS-1:0] valid_s1;
   logic [NO_OF_SENSORS-1:0] valid_s2;

   always_ff @(posedge s_apb_clk or negedge s_apb_rstn) begin
      if (!s_apb_rstn) begin
         valid_s1 <= '0;
         valid_s2 <= '0;
      end else begin
         valid_s1 <= sif.sens_valid;
         valid_s2 <= valid_s1;
      end
   end

   assign valid_use = valid_s2;
`else
   assign valid_use = sif.sens_valid;
`endif

   // Descending scan so the last hit is the lowest masked index >= idx
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int unsigned i = NO_OF_SENSORS; i > 0; i--) begin
         if (mask_q[i-1] && (IW'(i-1) >= idx)) begin
            found = 1'b1;
            sel   = IDX_W'(i-1);
         end
      end
   end

   always_comb begin
      cur_data = '0;
      for (int unsigned i = 0; i < NO_OF_SENSORS; i++) begin
         if (IDX_W'(i) == cur) cur_data = sif.sens_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge s_apb_clk or negedge s_apb_rstn) begin
      if (!s_apb_rstn) begin
         state           <= ST_IDLE;
         idx             <= '0;
         mask_q          <= '0;
         settle_q        <= '0;
         timeout_q       <= '0;
         cont_q          <= 1'b0;
         set_cnt         <= '0;
         timer           <= '0;
         done            <= 1'b0;
         err_cnt         <= '0;
         sif.sens_en     <= '0;
         sif.res_wr      <= 1'b0;
         sif.res_idx     <= '0;
         sif.res_data    <= '0;
         sif.res_timeout <= 1'b0;
      end else begin
         done       <= 1'b0;
         sif.res_wr <= 1'b0;
         if (cfg_abort && (state != ST_IDLE)) begin
            state       <= ST_IDLE;
            sif.sens_en <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (cfg_start && !cfg_abort) begin
                     mask_q    <= cfg_mask;
                     settle_q  <= cfg_settle;
                     timeout_q <= cfg_timeout;
                     cont_q    <= cfg_continuous;
                     err_cnt   <= '0;
                     idx       <= '0;
                     if (cfg_mask == '0) done  <= 1'b1;
                     else                state <= ST_SELECT;
                  end
               end
               ST_SELECT: begin
                  if (found) begin
                     state            <= ST_ENABLE;
                     set_cnt          <= (settle_q == 8'd0) ? 8'd1 : settle_q;
                     sif.sens_en      <= '0;
                     sif.sens_en[sel] <= 1'b1;
                     idx              <= IW'(sel);
                  end else if (cont_q) begin
                     idx <= '0;
                  end else begin
                     done  <= 1'b1;
                     state <= ST_IDLE;
                  end
               end
               ST_ENABLE: begin
                  if (set_cnt <= 8'd1) begin
                     sif.sens_en <= '0;
                     timer       <= '0;
                     state       <= ST_WAIT;
                  end else begin
                     set_cnt <= set_cnt - 8'd1;
                  end
               end
               ST_WAIT: begin
                  if (valid_use[cur]) begin
                     sif.res_wr      <= 1'b1;
                     sif.res_idx     <= cur;
                     sif.res_data    <= cur_data;
                     sif.res_timeout <= 1'b0;
                     state           <= ST_WRITE;
                  end else if (timer == timeout_q) begin
                     sif.res_wr      <= 1'b1;
                     sif.res_idx     <= cur;
                     sif.res_data    <= '0;
                     sif.res_timeout <= 1'b1;
                     if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                     state           <= ST_WRITE;
                  end else begin
                     timer <= timer + 16'd1;
                  end
               end
               ST_WRITE: begin
                  idx   <= idx + IW'(1);
                  state <= ST_SELECT;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_pvt_sensor_seq.sv
// Directed bench for pvt_sensor_seq: table of single-pass scans plus continuous,
// abort, start+abort and mid-scan reset sequences.
module tb_pvt_sensor_seq;
   localparam int N  = 8;
   localparam int DW = 16;
   localparam int IW = 3;

   typedef struct {
      logic [7:0]  mask;
      logic [7:0]  settle;
      logic [15:0] tmo;
      int          lat;        // valid this many cycles after enable falls, <0 = never
      logic [7:0]  xvalid;     // constant valid on these sensors
      bit          en_valid;   // selected sensor also raises valid while enabled
      int          exp_done;   // cycle of done pulse, start sampled in cycle 0
      int          exp_first_wr;
      logic [7:0]  exp_err;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cfg_start = 1'b0, cfg_abort = 1'b0, cfg_continuous = 1'b0;
   logic [N-1:0] cfg_mask = '0;
   logic [7:0]  cfg_settle = '0;
   logic [15:0] cfg_timeout = '0;
   logic        busy, done;
   logic [7:0]  err_cnt;

   pvt_sensor_seq_if #(.NO_OF_SENSORS(N), .DATA_WIDTH(DW), .IDX_W(IW)) sif ();

   pvt_sensor_seq #(.NO_OF_SENSORS(N), .DATA_WIDTH(DW), .IDX_W(IW)) dut (
      .s_apb_clk      (clk),
      .s_apb_rstn     (rst_n),
      .cfg_start      (cfg_start),
      .cfg_abort      (cfg_abort),
      .cfg_continuous (cfg_continuous),
      .cfg_mask       (cfg_mask),
      .cfg_settle     (cfg_settle),
      .cfg_timeout    (cfg_timeout),
      .busy           (busy),
      .done           (done),
      .err_cnt        (err_cnt),
      .sif            (sif)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   // Sensor responder
   int         lat = -1;
   logic [N-1:0] xvalid = '0;
   bit         en_valid = 1'b0;
   int         cd[N];
   logic [N-1:0] en_prev;

   initial begin
      logic [N-1:0] v;
      en_prev = '0;
      for (int i = 0; i < N; i++) cd[i] = 0;
      sif.sens_valid = '0;
      forever begin
         @(negedge clk);
         v = '0;
         for (int i = 0; i < N; i++) begin
            if (cd[i] > 0) begin
               cd[i]--;
               if (cd[i] == 0) v[i] = 1'b1;
            end
            if (en_prev[i] && !sif.sens_en[i] && lat >= 0) begin
               if (lat == 0) v[i] = 1'b1;
               else          cd[i] = lat;
            end
            if (en_valid && sif.sens_en[i]) v[i] = 1'b1;
         end
         en_prev = sif.sens_en;
         sif.sens_valid = v | xvalid;
      end
   end

   // Output monitor, sampled 1 time unit after each rising edge
   int cyc = 0;
   int c0 = 0;
   int wr_idx[$], wr_data[$], wr_to[$], wr_cyc[$];
   int en_cnt[N];
   int done_cnt, done_cyc, onehot_err;
   bit busy_seen;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (sif.res_wr === 1'b1) begin
            wr_idx.push_back(int'(sif.res_idx));
            wr_data.push_back(int'(sif.res_data));
            wr_to.push_back(int'(sif.res_timeout));
            wr_cyc.push_back(cyc - c0);
         end
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc - c0;
         end
         if (busy === 1'b1) busy_seen = 1'b1;
         for (int i = 0; i < N; i++) if (sif.sens_en[i] === 1'b1) en_cnt[i]++;
         if ($countones(sif.sens_en) > 1) onehot_err++;
      end
   end

   task automatic clear_logs();
      wr_idx.delete(); wr_data.delete(); wr_to.delete(); wr_cyc.delete();
      for (int i = 0; i < N; i++) en_cnt[i] = 0;
      done_cnt = 0; done_cyc = -1; onehot_err = 0; busy_seen = 1'b0;
   endtask

   task automatic run_vec(input int n, input vec_t v);
      int exp_i[$];
      int s;
      @(negedge clk);
      clear_logs();
      lat = v.lat; xvalid = v.xvalid; en_valid = v.en_valid;
      cfg_mask = v.mask; cfg_settle = v.settle; cfg_timeout = v.tmo;
      cfg_continuous = 1'b0; cfg_start = 1'b1; c0 = cyc;
      @(negedge clk);
      // Scrambled config after start must have no effect
      cfg_start = 1'b0; cfg_mask = ~v.mask; cfg_settle = 8'd9; cfg_timeout = 16'd1; cfg_continuous = 1'b1;
      for (int k = 0; k < 300 && done_cnt == 0; k++) @(negedge clk);
      repeat (4) @(negedge clk);

      s = (v.settle == 8'd0) ? 1 : int'(v.settle);
      for (int i = 0; i < N; i++) if (v.mask[i]) exp_i.push_back(i);

      chk($sformatf("v%0d_done_cyc", n), done_cyc, v.exp_done);
      chk($sformatf("v%0d_done_cnt", n), done_cnt, 1);
      chk($sformatf("v%0d_busy_end", n), busy, 1'b0);
      chk($sformatf("v%0d_busy_seen", n), busy_seen, (v.mask != 0));
      chk($sformatf("v%0d_err_cnt", n), err_cnt, v.exp_err);
      chk($sformatf("v%0d_wr_count", n), wr_idx.size(), exp_i.size());
      for (int j = 0; j < exp_i.size() && j < wr_idx.size(); j++) begin
         chk($sformatf("v%0d_wr%0d_idx", n, j), wr_idx[j], exp_i[j]);
         chk($sformatf("v%0d_wr%0d_data", n, j), wr_data[j], (v.lat >= 0) ? 32'h1000 + exp_i[j] : 0);
         chk($sformatf("v%0d_wr%0d_to", n, j), wr_to[j], (v.lat < 0));
      end
      chk($sformatf("v%0d_first_wr_cyc", n), (wr_cyc.size() > 0) ? wr_cyc[0] : -1, v.exp_first_wr);
      for (int i = 0; i < N; i++)
         chk($sformatf("v%0d_en%0d_cycles", n, i), en_cnt[i], v.mask[i] ? s : 0);
      chk($sformatf("v%0d_onehot", n), onehot_err, 0);
      if (exp_i.size() > 0)
         chk($sformatf("v%0d_res_idx_hold", n), sif.res_idx, exp_i[exp_i.size()-1]);
      cfg_mask = '0; cfg_settle = '0; cfg_timeout = '0; cfg_continuous = 1'b0;
      lat = -1; xvalid = '0; en_valid = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   vec_t vecs[7];

   initial begin
      bit ok;
      int n_wr;

      vecs[0] = '{8'hA5, 8'd3, 16'd100,  4, 8'h00, 1'b0, 42, 10, 8'd0};
      vecs[1] = '{8'h10, 8'd0, 16'd5,   -1, 8'h00, 1'b0, 11,  9, 8'd1};
      vecs[2] = '{8'h00, 8'd3, 16'd10,   4, 8'h00, 1'b0,  1, -1, 8'd0};
      vecs[3] = '{8'h81, 8'd2, 16'd0,    0, 8'h00, 1'b0, 12,  5, 8'd0};
      vecs[4] = '{8'h06, 8'd1, 16'd2,   -1, 8'h00, 1'b0, 14,  6, 8'd2};
      vecs[5] = '{8'hFF, 8'd5, 16'd3,    3, 8'h00, 1'b0, 90, 11, 8'd0};
      vecs[6] = '{8'h04, 8'd3, 16'd4,   -1, 8'hFB, 1'b1, 12, 10, 8'd1};

      for (int i = 0; i < N; i++) sif.sens_data[i*DW +: DW] = 16'h1000 + 16'(i);
      clear_logs();

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset_outputs", {sif.sens_en, sif.res_wr, sif.res_idx, sif.res_data, sif.res_timeout, busy, done, err_cnt}, 64'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("idle_outputs", {sif.sens_en, sif.res_wr, sif.res_idx, sif.res_data, sif.res_timeout, busy, done, err_cnt}, 64'd0);

      for (int n = 0; n < 7; n++) run_vec(n, vecs[n]);

      // Continuous scan, then abort in the middle of WAIT
      @(negedge clk);
      clear_logs();
      lat = 2; cfg_mask = 8'h03; cfg_settle = 8'd1; cfg_timeout = 16'd50;
      cfg_continuous = 1'b1; cfg_start = 1'b1; c0 = cyc;
      @(negedge clk);
      cfg_start = 1'b0; cfg_continuous = 1'b0;
      for (int k = 0; k < 200 && wr_idx.size() < 5; k++) @(negedge clk);
      chk("cont_wr_count_ge5", (wr_idx.size() >= 5), 1'b1);
      for (int j = 0; j < 5 && j < wr_idx.size(); j++)
         chk($sformatf("cont_wr%0d_idx", j), wr_idx[j], j % 2);
      chk("cont_no_done", done_cnt, 0);
      chk("cont_busy", busy, 1'b1);
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (sif.sens_en != '0) begin ok = 1'b1; break; end
      end
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (sif.sens_en == '0) break;
      end
      chk("cont_en_seen", ok, 1'b1);
      cfg_abort = 1'b1;
      n_wr = wr_idx.size();
      @(negedge clk);
      cfg_abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_en", sif.sens_en, 0);
      repeat (20) @(negedge clk);
      chk("abort_no_wr", wr_idx.size(), n_wr);
      chk("abort_no_done", done_cnt, 0);
      chk("abort_idle", busy, 1'b0);
      lat = -1; cfg_mask = '0;

      // Start and abort in the same cycle
      @(negedge clk);
      clear_logs();
      cfg_mask = 8'hFF; cfg_settle = 8'd2; cfg_timeout = 16'd5;
      cfg_start = 1'b1; cfg_abort = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0; cfg_abort = 1'b0;
      repeat (6) @(negedge clk);
      chk("sa_busy_seen", busy_seen, 1'b0);
      chk("sa_no_wr", wr_idx.size(), 0);
      chk("sa_no_done", done_cnt, 0);
      chk("sa_no_en", en_cnt[0] + en_cnt[7], 0);

      // Asynchronous reset during ENABLE
      cfg_mask = 8'h01; cfg_settle = 8'd5; cfg_timeout = 16'd20; cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (sif.sens_en != '0) begin ok = 1'b1; break; end
      end
      chk("rst_en_seen", ok, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_en", sif.sens_en, 0);
      chk("rst_async_busy", busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_after_outputs", {sif.sens_en, sif.res_wr, sif.res_idx, sif.res_data, sif.res_timeout, busy, done, err_cnt}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end
endmodule
